// File: rtl/wide_alu_seq.sv
// 16-bit ADD/OR/AND/XOR/EQ/SHL1 sequencer driving an 8-bit combinational ALU in byte passes.
// Latency: done 3 cycles after accept (4 for ADD16/SHL1_16); start is ignored while busy, nothing queued.
module wide_alu_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic        carry,
   output logic        eq,
   output logic        err,
   output logic [2:0]  alu_cmd,
   output logic [7:0]  alu_inA,
   output logic [7:0]  alu_inB,
   output logic        alu_sc_i,
   output logic        alu_negAddi,
   input  logic [7:0]  alu_rslt,
   input  logic        alu_sc_o,
   input  logic        alu_zero
);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_XOR = 3'd3;
   localparam logic [2:0] OP_EQ  = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;

   typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [2:0]  op_q;
   logic [15:0] a_q, b_q;
   logic [7:0]  r_lo, r_hi;
   logic        c_lo, c_hi, z_lo;
   logic [2:0]  byte_cmd;
   logic        needs_fix, is_illegal;

   assign needs_fix  = (op_q == OP_ADD) || (op_q == OP_SHL);
   assign is_illegal = (op_q > OP_SHL);
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);
   assign alu_sc_i    = 1'b0;
   assign alu_negAddi = 1'b0;

   always_comb begin
      byte_cmd = 3'b111;
      case (op_q)
         OP_ADD:  byte_cmd = 3'b000;
         OP_OR:   byte_cmd = 3'b010;
         OP_AND:  byte_cmd = 3'b011;
         OP_XOR:  byte_cmd = 3'b100;
         OP_EQ:   byte_cmd = 3'b101;
         OP_SHL:  byte_cmd = 3'b001;
         default: byte_cmd = 3'b111;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      alu_cmd   = 3'b111;
      alu_inA   = 8'h00;
      alu_inB   = 8'h00;
      case (state)
         S_IDLE: if (start) state_nxt = S_LO;
         S_LO: begin
            alu_cmd   = byte_cmd;
            alu_inA   = a_q[7:0];
            alu_inB   = (op_q == OP_SHL) ? 8'h01 : b_q[7:0];
            state_nxt = S_HI;
         end
         S_HI: begin
            alu_cmd   = byte_cmd;
            alu_inA   = a_q[15:8];
            alu_inB   = (op_q == OP_SHL) ? 8'h01 : b_q[15:8];
            state_nxt = needs_fix ? S_FIX : S_DONE;
         end
         S_FIX: begin
            // Fold the low-byte carry/shift-out into the high byte: ADD for ADD16, OR for SHL1_16.
            alu_cmd   = (op_q == OP_ADD) ? 3'b000 : 3'b010;
            alu_inA   = r_hi;
            alu_inB   = {7'b0, c_lo};
            state_nxt = S_DONE;
         end
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= 3'd0;
         a_q    <= 16'h0000;
         b_q    <= 16'h0000;
         r_lo   <= 8'h00;
         r_hi   <= 8'h00;
         c_lo   <= 1'b0;
         c_hi   <= 1'b0;
         z_lo   <= 1'b0;
         result <= 16'h0000;
         carry  <= 1'b0;
         eq     <= 1'b0;
         err    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q <= op;
               a_q  <= a;
               b_q  <= b;
            end
            S_LO: begin
               r_lo <= alu_rslt;
               c_lo <= alu_sc_o;
               z_lo <= alu_zero;
            end
            S_HI: begin
               r_hi <= alu_rslt;
               c_hi <= alu_sc_o;
               // Ops without a fix-up pass publish their outputs on the HI -> DONE edge.
               if (!needs_fix) begin
                  result <= (is_illegal || op_q == OP_EQ) ? 16'h0000 : {alu_rslt, r_lo};
                  carry  <= 1'b0;
                  eq     <= (op_q == OP_EQ) && z_lo && alu_zero;
                  err    <= is_illegal;
               end
            end
            S_FIX: begin
               r_hi   <= alu_rslt;
               result <= {alu_rslt, r_lo};
               carry  <= (op_q == OP_ADD) ? (c_hi | alu_sc_o) : c_hi;
               eq     <= 1'b0;
               err    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wide_alu_seq.sv
// Directed bench for wide_alu_seq with a behavioural 8-bit ALU model on the ALU side.
module tb_wide_alu_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [15:0] a, b;
   logic        busy, done, carry, eq, err;
   logic [15:0] result;
   logic [2:0]  alu_cmd;
   logic [7:0]  alu_inA, alu_inB, alu_rslt;
   logic        alu_sc_i, alu_negAddi, alu_sc_o, alu_zero;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wide_alu_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry(carry), .eq(eq), .err(err),
      .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB),
      .alu_sc_i(alu_sc_i), .alu_negAddi(alu_negAddi),
      .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o), .alu_zero(alu_zero)
   );

   // Reference 8-bit ALU: sc_o is add carry-out or the bit shifted out of the MSB.
   always_comb begin
      logic [8:0]  wide;
      logic [15:0] sh;
      wide     = 9'h000;
      sh       = 16'h0000;
      alu_sc_o = 1'b0;
      alu_rslt = 8'h00;
      case (alu_cmd)
         3'b000: begin wide = {1'b0, alu_inA} + {1'b0, alu_inB}; alu_rslt = wide[7:0]; alu_sc_o = wide[8]; end
         3'b001: begin sh = {8'h00, alu_inA} << alu_inB[2:0]; alu_rslt = sh[7:0]; alu_sc_o = sh[8]; end
         3'b010: alu_rslt = alu_inA | alu_inB;
         3'b011: alu_rslt = alu_inA & alu_inB;
         3'b100: alu_rslt = alu_inA ^ alu_inB;
         3'b101: alu_rslt = alu_inA ^ alu_inB;
         default: alu_rslt = alu_inA;
      endcase
      alu_zero = (alu_rslt == 8'h00);
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        c;
      logic        e;
      logic        er;
      int          lat;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];

   // Accept one op, then step cycle by cycle until done; checks latency, busy and all outputs.
   task automatic run_op(input string nm, input vec_t v);
      int  lat;
      bit  busy_ok;
      @(negedge clk);
      start = 1'b1; op = v.op; a = v.a; b = v.b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0; a = 16'hDEAD; b = 16'hBEEF;
      lat = 1;
      busy_ok = 1'b1;
      while (!done && lat < 8) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL %s timeout: no done within %0d cycles", nm, lat);
      end else begin
         check({nm, " busy_during"}, {31'b0, busy_ok & busy}, 32'd1);
         check({nm, " latency"}, lat, v.lat);
         check({nm, " result"}, {16'b0, result}, {16'b0, v.res});
         check({nm, " carry"}, {31'b0, carry}, {31'b0, v.c});
         check({nm, " eq"}, {31'b0, eq}, {31'b0, v.e});
         check({nm, " err"}, {31'b0, err}, {31'b0, v.er});
      end
      @(posedge clk);
      #1;
      check({nm, " idle_after"}, {30'b0, busy, done}, 32'd0);
      check({nm, " held_result"}, {16'b0, result}, {16'b0, v.res});
   endtask

   initial begin
      int n_done;
      vecs[0]  = '{3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 1'b0, 4};
      vecs[1]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
      vecs[2]  = '{3'd0, 16'h7F80, 16'h0080, 16'h8000, 1'b0, 1'b0, 1'b0, 4};
      vecs[3]  = '{3'd0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0, 4};
      vecs[4]  = '{3'd5, 16'h80C1, 16'h5555, 16'h0182, 1'b1, 1'b0, 1'b0, 4};
      vecs[5]  = '{3'd5, 16'h4001, 16'h0000, 16'h8002, 1'b0, 1'b0, 1'b0, 4};
      vecs[6]  = '{3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 3};
      vecs[7]  = '{3'd1, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 3};
      vecs[8]  = '{3'd3, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b0, 1'b0, 3};
      vecs[9]  = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 3};
      vecs[10] = '{3'd4, 16'h1234, 16'h1235, 16'h0000, 1'b0, 1'b0, 1'b0, 3};
      vecs[11] = '{3'd4, 16'h1234, 16'h1334, 16'h0000, 1'b0, 1'b0, 1'b0, 3};
      vecs[12] = '{3'd7, 16'hABCD, 16'h1111, 16'h0000, 1'b0, 1'b0, 1'b1, 3};
      vecs[13] = '{3'd6, 16'h0F00, 16'h00F0, 16'h0000, 1'b0, 1'b0, 1'b1, 3};

      reset = 1'b1; start = 1'b0; op = 3'd0; a = 16'h0; b = 16'h0;
      repeat (2) @(negedge clk);
      check("rst busy_done", {30'b0, busy, done}, 32'd0);
      check("rst result", {16'b0, result}, 32'd0);
      check("rst flags", {29'b0, carry, eq, err}, 32'd0);
      check("rst alu_cmd", {29'b0, alu_cmd}, 32'd7);
      check("rst alu_in", {16'b0, alu_inA, alu_inB}, 32'd0);
      check("rst alu_fixed", {30'b0, alu_sc_i, alu_negAddi}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) run_op($sformatf("vec%0d", i), vecs[i]);

      // Start re-asserted during HI and again during DONE must be ignored.
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 16'h00FF; b = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      start = 1'b1; op = 3'd1; a = 16'hAAAA; b = 16'h5555;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign fix_state", {30'b0, busy, done}, 32'd2);
      @(posedge clk); #1;
      check("ign done_t4", {31'b0, done}, 32'd1);
      check("ign result", {16'b0, result}, 32'h0100);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("ign busy_after", {31'b0, busy}, 32'd0);
      n_done = 0;
      repeat (6) begin @(posedge clk); #1; if (done) n_done++; end
      check("ign extra_done", n_done, 0);

      // Reset while in HI abandons the op immediately.
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 16'hFFFF; b = 16'h0001;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("rhi in_hi", {29'b0, alu_cmd}, 32'd0);
      reset = 1'b1;
      #1;
      check("rhi busy_done", {30'b0, busy, done}, 32'd0);
      check("rhi alu_cmd", {29'b0, alu_cmd}, 32'd7);
      check("rhi result", {16'b0, result}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      n_done = 0;
      repeat (6) begin @(posedge clk); #1; if (done) n_done++; end
      check("rhi no_done", n_done, 0);
      run_op("after_rst", '{3'd0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0, 4});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
